i2s_audio_rx: RTL and testbench



---
 rtl/i2s_audio_rx.sv | 168 ++++++++++++++++
 tb/tb_i2s_audio_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx
// Receiver for the core's serial audio stream (lrck / data), clocked by the
// audio master clock. Each lrck half-frame (slot) carries one signed word.
// Bit 0 of a slot is the one-bit delay, bits 1..SAMPLE_WIDTH carry the word
// MSB first, and the remaining bits are padding. Completed words are presented
// as a one-cycle pulse and latched into the left/right holding registers.
//
// Optional feature macro: I2S_AUDIO_RX_PAD_CHECK_EN
//   defined   : the delay bit and padding bits are checked, and any 1 pulses
//               pad_error.
//   undefined : no check logic is built, and pad_error is tied low.
//
// Ports:
//   clk            in   audio master clock, the only clock
//   reset          in   asynchronous, active-high reset
//   i2s_lrck       in   word select: 0 = left slot, 1 = right slot
//   i2s_data       in   serial data, MSB first, one-bit delay after lrck change
//   sample_valid   out  one-cycle pulse when a slot word completes
//   sample_channel out  lrck level of the completed slot
//   sample_data    out  completed word
//   left_sample    out  last complete left word
//   right_sample   out  last complete right word
//   pair_valid     out  pulse with a right word that directly follows a left word
//   framing_error  out  one-cycle pulse on a slot-length violation
//   pad_error      out  one-cycle pulse on a nonzero delay/padding bit
//   dbg_state_o    out  FSM state (0 = HUNT, 1 = RX)
//
// Handshake: the outputs are push-only with no ready signal. sample_valid,
// pair_valid, framing_error and pad_error are single-cycle strobes, and
// sample_data/sample_channel are meaningful in the cycle sample_valid is high.
module i2s_audio_rx #(
   parameter int CLKS_PER_BIT  = 4,
   parameter int BITS_PER_SLOT = 32,
   parameter int SAMPLE_WIDTH  = 16,
   parameter int SAMPLE_PHASE  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i2s_lrck,
   input  logic                    i2s_data,
   output logic                    sample_valid,
   output logic                    sample_channel,
   output logic [SAMPLE_WIDTH-1:0] sample_data,
   output logic [SAMPLE_WIDTH-1:0] left_sample,
   output logic [SAMPLE_WIDTH-1:0] right_sample,
   output logic                    pair_valid,
   output logic                    framing_error,
   output logic                    pad_error,
   output logic                    dbg_state_o
);

   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (BITS_PER_SLOT > 1) ? $clog2(BITS_PER_SLOT) : 1;
   localparam logic [PW-1:0] PH_ONE    = PW'(1);
   localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_SLOT - 1);
   localparam logic [BW-1:0] BIT_LSB   = BW'(SAMPLE_WIDTH);

   typedef enum logic {HUNT = 1'b0, RX = 1'b1} state_t;

   state_t                  state_q;
   logic                    lrck_q;
   logic                    last_q;
   logic                    left_seen_q;
   logic [PW-1:0]           phase_q, phase_d, cur_phase;
   logic [BW-1:0]           bit_q, bit_d, cur_bit;
   logic [SAMPLE_WIDTH-2:0] shift_q;
   logic                    lrck_edge, last_pos, early_edge, late_edge;
   logic                    sample_pt, word_bit, word_done;
   logic [SAMPLE_WIDTH-1:0] word;

   // cur_phase/cur_bit give the position of the current cycle inside the
   // slot. An lrck edge makes this cycle position (0,0) regardless of the
   // stored counters, so the counters store the position of the next cycle.
   always_comb begin
      lrck_edge = i2s_lrck ^ lrck_q;
      cur_phase = lrck_edge ? '0 : phase_q;
      cur_bit   = lrck_edge ? '0 : bit_q;
      last_pos  = (cur_phase == PH_LAST) && (cur_bit == BIT_LAST);
      phase_d   = (cur_phase == PH_LAST) ? '0 : cur_phase + PH_ONE;
      bit_d     = cur_bit;
      if (cur_phase == PH_LAST) begin
         bit_d = (cur_bit == BIT_LAST) ? '0 : cur_bit + BIT_ONE;
      end
      // last_q marks that the previous cycle was the final cycle of a slot.
      // An edge is legal only there. Missing it there means the slot ran long.
      early_edge = (state_q == RX) && lrck_edge && !last_q;
      late_edge  = (state_q == RX) && !lrck_edge && last_q;
      sample_pt  = ((state_q == RX) || lrck_edge) && !late_edge && (cur_phase == PH_SAMPLE);
      word_bit   = sample_pt && (cur_bit >= BIT_ONE) && (cur_bit <= BIT_LSB);
      word_done  = sample_pt && (cur_bit == BIT_LSB);
      word       = {shift_q, i2s_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= HUNT;
         lrck_q         <= 1'b0;
         phase_q        <= '0;
         bit_q          <= '0;
         last_q         <= 1'b0;
         left_seen_q    <= 1'b0;
         shift_q        <= '0;
         sample_valid   <= 1'b0;
         sample_channel <= 1'b0;
         sample_data    <= '0;
         left_sample    <= '0;
         right_sample   <= '0;
         pair_valid     <= 1'b0;
         framing_error  <= 1'b0;
      end else begin
         lrck_q        <= i2s_lrck;
         phase_q       <= phase_d;
         bit_q         <= bit_d;
         last_q        <= last_pos;
         sample_valid  <= 1'b0;
         pair_valid    <= 1'b0;
         framing_error <= early_edge || late_edge;

         case (state_q)
            HUNT: begin
               left_seen_q <= 1'b0;
               if (lrck_edge) state_q <= RX;
            end
            RX: begin
               // An early edge restarts the slot in RX. The partial word is
               // discarded because its completion point never arrives.
               if (early_edge || late_edge) left_seen_q <= 1'b0;
               if (late_edge) state_q <= HUNT;
            end
         endcase

         if (word_bit) shift_q <= word[SAMPLE_WIDTH-2:0];

         if (word_done) begin
            sample_valid   <= 1'b1;
            sample_data    <= word;
            sample_channel <= i2s_lrck;
            if (i2s_lrck) begin
               right_sample <= word;
               pair_valid   <= left_seen_q;
               left_seen_q  <= 1'b0;
            end else begin
               left_sample  <= word;
               left_seen_q  <= 1'b1;
            end
         end
      end
   end

`ifdef I2S_AUDIO_RX_PAD_CHECK_EN
   // Every sample point that is not a word bit is either the delay bit or padding.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_error <= 1'b0;
      end else begin
         pad_error <= sample_pt && !word_bit && i2s_data;
      end
   end
`else
   assign pad_error = 1'b0;
`endif

   assign dbg_state_o = (state_q == RX);

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Testbench for i2s_audio_rx with default parameters (4 clk/bit, 32 bits/slot,
// 16-bit words, sample phase 2).
// Inputs change 2 time units after a rising edge. Outputs are observed
// 1 time unit after a rising edge. cyc numbers the clock intervals, so a
// slot whose lrck change is driven in interval t0 produces its word in
// interval t0 + 16*4 + 2 + 1.
module tb_i2s_audio_rx;

   localparam int CPB = 4;
   localparam int SW  = 16;
   localparam int LAT = SW * CPB + 2 + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i2s_lrck = 1'b0;
   logic          i2s_data = 1'b0;
   logic          sample_valid, sample_channel, pair_valid;
   logic          framing_error, pad_error, dbg_state_o;
   logic [SW-1:0] sample_data, left_sample, right_sample;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Expected word entries: {interval[31:0], channel, pair_valid, data[15:0]}.
   logic [49:0] exp_q[$];
   int          ferr_q[$];
   int          pad_q[$];

   typedef struct {
      logic        lr;
      logic [15:0] word;
      int          len;
      int          pad_bit;
      logic        exp_valid;
      logic        exp_pair;
      int          ferr_ofs;
   } row_t;

   i2s_audio_rx dut (
      .clk            (clk),
      .reset          (reset),
      .i2s_lrck       (i2s_lrck),
      .i2s_data       (i2s_data),
      .sample_valid   (sample_valid),
      .sample_channel (sample_channel),
      .sample_data    (sample_data),
      .left_sample    (left_sample),
      .right_sample   (right_sample),
      .pair_valid     (pair_valid),
      .framing_error  (framing_error),
      .pad_error      (pad_error),
      .dbg_state_o    (dbg_state_o)
   );

   // Clock and interval counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sample_valid"},   32'(sample_valid),   32'd0);
      chk({tag, "_sample_channel"}, 32'(sample_channel), 32'd0);
      chk({tag, "_sample_data"},    32'(sample_data),    32'd0);
      chk({tag, "_left_sample"},    32'(left_sample),    32'd0);
      chk({tag, "_right_sample"},   32'(right_sample),   32'd0);
      chk({tag, "_pair_valid"},     32'(pair_valid),     32'd0);
      chk({tag, "_framing_error"},  32'(framing_error),  32'd0);
      chk({tag, "_pad_error"},      32'(pad_error),      32'd0);
      chk({tag, "_state_hunt"},     32'(dbg_state_o),    32'd0);
   endtask

   // Serial bit k of a slot carrying word w; bit pad_bit (if any) is forced to 1.
   function automatic logic slot_bit(input logic [15:0] w, input int k, input int pad_bit);
      if (k >= 1 && k <= SW) return w[SW - k];
      return (k == pad_bit);
   endfunction

   // Drives one slot of len intervals and records what the receiver must emit.
   task automatic drive_slot(input logic lr, input logic [15:0] w, input int len,
                             input int pad_bit, input logic exp_valid,
                             input logic exp_pair, input int ferr_ofs);
      int t0;
      t0 = cyc;
      if (exp_valid) exp_q.push_back({32'(t0 + LAT), lr, exp_pair, w});
      if (ferr_ofs > 0) ferr_q.push_back(t0 + ferr_ofs);
`ifdef I2S_AUDIO_RX_PAD_CHECK_EN
      if (pad_bit >= 0) pad_q.push_back(t0 + pad_bit * CPB + 2 + 1);
`endif
      for (int c = 0; c < len; c++) begin
         i2s_lrck = lr;
         i2s_data = slot_bit(w, c / CPB, pad_bit);
         @(posedge clk);
         #2;
      end
   endtask

   // Scoreboard: pops an expectation whenever the DUT emits a pulse.
   initial begin
      logic [49:0] e;
      int          t;
      forever begin
         @(posedge clk);
         #1;
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid at cycle %0d: actual data=%h required no output", cyc, sample_data);
            end else begin
               e = exp_q.pop_front();
               chk("valid_cycle", 32'(cyc), e[49:18]);
               chk("sample_channel", 32'(sample_channel), 32'(e[17]));
               chk("pair_valid", 32'(pair_valid), 32'(e[16]));
               chk("sample_data", 32'(sample_data), 32'(e[15:0]));
               if (e[17]) chk("right_sample", 32'(right_sample), 32'(e[15:0]));
               else       chk("left_sample", 32'(left_sample), 32'(e[15:0]));
            end
         end else if (pair_valid) begin
            checks++;
            failures++;
            $display("FAIL pair_without_valid at cycle %0d: actual=1 required=0", cyc);
         end
         if (framing_error) begin
            if (ferr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_framing_error at cycle %0d: actual=1 required=0", cyc);
            end else begin
               t = ferr_q.pop_front();
               chk("framing_error_cycle", 32'(cyc), 32'(t));
            end
         end
         if (pad_error) begin
            if (pad_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pad_error at cycle %0d: actual=1 required=0", cyc);
            end else begin
               t = pad_q.pop_front();
               chk("pad_error_cycle", 32'(cyc), 32'(t));
            end
         end
      end
   end

   initial begin
      row_t tbl[13];
      //            lr    word      len  pad  valid pair  ferr
      tbl[0]  = '{1'b1, 16'h7FFE, 128, -1, 1'b1, 1'b0, 0};  // first slot after hunt
      tbl[1]  = '{1'b0, 16'h8001, 128, -1, 1'b1, 1'b0, 0};
      tbl[2]  = '{1'b1, 16'h7FFE, 128, -1, 1'b1, 1'b1, 0};  // stereo pair
      tbl[3]  = '{1'b0, 16'h1234,  40, -1, 1'b0, 1'b0, 0};  // cut 40 cycles in
      tbl[4]  = '{1'b1, 16'hA5A5, 128, -1, 1'b1, 1'b0, 1};  // early edge flagged
      tbl[5]  = '{1'b0, 16'h0F0F, 128, -1, 1'b1, 1'b0, 0};
      tbl[6]  = '{1'b1, 16'hF0F0, 100, -1, 1'b1, 1'b1, 0};  // short in padding
      tbl[7]  = '{1'b0, 16'h8001, 128, -1, 1'b1, 1'b0, 1};
      tbl[8]  = '{1'b1, 16'h7FFE, 128, -1, 1'b1, 1'b1, 0};
      tbl[9]  = '{1'b0, 16'h1234, 128, 20, 1'b1, 1'b0, 0};  // padding bit 20 set
      tbl[10] = '{1'b1, 16'h0000, 128, -1, 1'b1, 1'b1, 0};
      tbl[11] = '{1'b0, 16'hFFFF,  67, -1, 1'b1, 1'b0, 0};  // edge on completion cycle
      tbl[12] = '{1'b1, 16'h8000, 128, -1, 1'b1, 1'b0, 1};  // left cleared by error

      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      chk_all_zero("reset");
      reset = 1'b0;

      // Start mid-slot: lrck stays at its reset level, so nothing is decoded.
      drive_slot(1'b0, 16'hFFFF, 60, -1, 1'b0, 1'b0, 0);
      chk("midslot_state_hunt", 32'(dbg_state_o), 32'd0);

      for (int i = 0; i < 13; i++) begin
         drive_slot(tbl[i].lr, tbl[i].word, tbl[i].len, tbl[i].pad_bit,
                    tbl[i].exp_valid, tbl[i].exp_pair, tbl[i].ferr_ofs);
      end
      chk("table_left_sample", 32'(left_sample), 32'h0000FFFF);
      chk("table_right_sample", 32'(right_sample), 32'h00008000);

      // lrck held for 200 cycles: one word, then a late-edge error and HUNT.
      drive_slot(1'b0, 16'h5555, 200, -1, 1'b1, 1'b0, 129);
      chk("late_state_hunt", 32'(dbg_state_o), 32'd0);
      chk("late_left_sample", 32'(left_sample), 32'h00005555);
      chk("late_right_sample", 32'(right_sample), 32'h00008000);
      drive_slot(1'b1, 16'h6666, 128, -1, 1'b1, 1'b0, 0);
      chk("resync_state_rx", 32'(dbg_state_o), 32'd1);

      // Reset 30 cycles into a left slot.
      drive_slot(1'b0, 16'h3C3C, 30, -1, 1'b0, 1'b0, 0);
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      drive_slot(1'b0, 16'h3C3C, 80, -1, 1'b0, 1'b0, 0);
      chk("post_reset_state_hunt", 32'(dbg_state_o), 32'd0);
      drive_slot(1'b1, 16'h1357, 128, -1, 1'b1, 1'b0, 0);
      drive_slot(1'b0, 16'h2468, 128, -1, 1'b1, 1'b0, 0);
      drive_slot(1'b1, 16'h9ABC, 128, -1, 1'b1, 1'b1, 0);
      drive_slot(1'b0, 16'h0000,   8, -1, 1'b0, 1'b0, 0);

      chk("final_left_sample", 32'(left_sample), 32'h00002468);
      chk("final_right_sample", 32'(right_sample), 32'h00009ABC);
      chk("words_outstanding", 32'(exp_q.size()), 32'd0);
      chk("framing_errors_outstanding", 32'(ferr_q.size()), 32'd0);
      chk("pad_errors_outstanding", 32'(pad_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
